// File: rtl/acc_job_dispatcher.sv
// acc_job_dispatcher: buffers operand jobs in a small FIFO, drives one job at a
// time into a scheduled accelerator (start / op_ready / result_en / done_next),
// and returns each result, or a timeout error, on a registered output slot.
//
// Handshake rule for both streams: a transfer happens on the rising clk edge
// where valid && ready are both high. A valid source holds its data until that
// edge. ready may depend on internal state only, never combinationally on valid.
module acc_job_dispatcher #(
  parameter int DW      = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          acc_op_ready,
  output logic          acc_start,
  output logic [DW-1:0] acc_a,
  output logic [DW-1:0] acc_b,
  input  logic          acc_result_en,
  input  logic [DW-1:0] acc_result,
  input  logic          acc_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_err,
  output logic          busy,
  output logic [7:0]    job_count,
  output logic [1:0]    dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Job FIFO storage and bookkeeping
  logic [DW-1:0] mem_a_q [DEPTH];
  logic [DW-1:0] mem_b_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Dispatcher state
  state_t        state_q;
  logic [DW-1:0] acc_a_q, acc_b_q;
  logic [DW-1:0] result_q;
  logic [TW-1:0] timer_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          out_err_q;
  logic [7:0]    job_count_q;

  logic push, pop;

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // A new job starts only when the accelerator is idle and the previous result
  // has left the output slot, so jobs never overlap.
  assign pop      = (state_q == IDLE) && (count_q != '0) && acc_op_ready && !out_valid_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO payload write; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  // Dispatch FSM, operand latches, watchdog timer and output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      result_q    <= '0;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      job_count_q <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        job_count_q <= job_count_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (pop) begin
            acc_a_q  <= mem_a_q[rd_ptr_q];
            acc_b_q  <= mem_b_q[rd_ptr_q];
            result_q <= '0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (acc_result_en) result_q <= acc_result;
          if (acc_done) begin
            // A result strobe in the done cycle is forwarded directly.
            out_valid_q <= 1'b1;
            out_data_q  <= acc_result_en ? acc_result : result_q;
            out_err_q   <= 1'b0;
            state_q     <= IDLE;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            out_err_q   <= 1'b1;
            state_q     <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign acc_start = (state_q == ISSUE);
  assign acc_a     = acc_a_q;
  assign acc_b     = acc_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign job_count = job_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_acc_job_dispatcher.sv
// Bench for acc_job_dispatcher: a 4-cycle accelerator model (result = a+b),
// directed steps in one initial block, and an expected-result queue.
module tb_acc_job_dispatcher;

  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          in_valid, in_ready;
  logic [DW-1:0] in_a, in_b;
  logic          acc_op_ready, acc_start;
  logic [DW-1:0] acc_a, acc_b;
  logic          acc_result_en;
  logic [DW-1:0] acc_result;
  logic          acc_done;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_err, busy;
  logic [7:0]    job_count;
  logic [1:0]    dbg_state;

  acc_job_dispatcher #(.DW(DW), .DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .acc_op_ready(acc_op_ready), .acc_start(acc_start),
    .acc_a(acc_a), .acc_b(acc_b),
    .acc_result_en(acc_result_en), .acc_result(acc_result), .acc_done(acc_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err),
    .busy(busy), .job_count(job_count), .dbg_state(dbg_state)
  );

  // ---------------- accelerator model ----------------
  // m_cnt = 1 in the start cycle, k+1 in the k-th cycle after start is sampled.
  logic [3:0] m_cnt;
  logic       no_done;
  logic       tb_stray;
  int         n_start;

  always @(negedge clk) begin
    if (rst) begin
      m_cnt <= 4'd0;
    end else if (acc_start) begin
      m_cnt   <= 4'd1;
      n_start <= n_start + 1;
    end else if (m_cnt == 4'd6) begin
      m_cnt <= 4'd0;
    end else if (m_cnt != 4'd0) begin
      m_cnt <= m_cnt + 4'd1;
    end
  end

  assign acc_op_ready  = (m_cnt == 4'd0);
  assign acc_result_en = (m_cnt == 4'd5);
  assign acc_result    = acc_result_en ? DW'(acc_a + acc_b) : 16'hdead;
  assign acc_done      = ((m_cnt == 4'd6) && !no_done) || tb_stray;

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        exp_timeout;
  logic        pushed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Account for the handshakes the coming edge performs, then advance one cycle.
  task automatic tick();
    logic [DW:0]   e;
    logic [DW-1:0] s;
    pushed = 1'b0;
    if (in_valid && in_ready) begin
      s = in_a + in_b;
      exp_q.push_back(exp_timeout ? {1'b1, {DW{1'b0}}} : {1'b0, s});
      pushed = 1'b1;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", {16'b0, out_data}, {16'b0, e[DW-1:0]});
        check("out_err", {31'b0, out_err}, {31'b0, e[DW]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_job(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int k = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    do begin
      tick();
      k++;
    end while (!pushed && k < 200);
    in_valid = 1'b0;
    check("push_accepted", {31'b0, pushed}, 32'd1);
  endtask

  task automatic wait_start(input int bound);
    int k = 0;
    while (!acc_start && k < bound) begin
      tick();
      k++;
    end
    check("start_seen", {31'b0, acc_start}, 32'd1);
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          n;
    int          s0;
    logic [DW:0] e0;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    no_done = 1'b0; tb_stray = 1'b0; exp_timeout = 1'b0; n_start = 0; pushed = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_acc_start", {31'b0, acc_start}, 32'd0);
    check("rst_acc_a", {16'b0, acc_a}, 32'd0);
    check("rst_acc_b", {16'b0, acc_b}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_job_count", {24'b0, job_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single job 3+5: one start, operands held, 6 cycles from start to out_valid
    push_job(16'd3, 16'd5);
    check("single_busy", {31'b0, busy}, 32'd1);
    check("single_idle_no_start", {31'b0, acc_start}, 32'd0);
    wait_start(10);
    check("single_acc_a", {16'b0, acc_a}, 32'd3);
    check("single_acc_b", {16'b0, acc_b}, 32'd5);
    wait_valid(40, n);
    check("single_latency", n, 32'd6);
    check("single_out_data", {16'b0, out_data}, 32'd8);
    check("single_out_err", {31'b0, out_err}, 32'd0);
    check("single_held_a", {16'b0, acc_a}, 32'd3);
    check("single_held_b", {16'b0, acc_b}, 32'd5);
    check("single_starts", n_start, 32'd1);
    out_ready = 1'b1;
    tick();
    check("single_job_count", {24'b0, job_count}, 32'd1);
    check("single_valid_clr", {31'b0, out_valid}, 32'd0);

    // Burst of 6: the FIFO fills after 5 pushes (one already popped)
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("burst_full", {31'b0, in_ready}, 32'd0);
      push_job(DW'($urandom_range(0, 16'hffff)), DW'($urandom_range(0, 16'hffff)));
    end
    drain(500);
    check("burst_job_count", {24'b0, job_count}, 32'd7);

    // Backpressure: result held, no second start while the slot is full
    out_ready = 1'b0;
    push_job(16'd100, 16'd23);
    push_job(16'd7, 16'd9);
    wait_valid(40, n);
    s0 = n_start;
    e0 = exp_q[0];
    repeat (20) tick();
    check("bp_valid_held", {31'b0, out_valid}, 32'd1);
    check("bp_data_held", {16'b0, out_data}, {16'b0, e0[DW-1:0]});
    check("bp_no_start", n_start, s0);
    out_ready = 1'b1;
    drain(100);
    check("bp_second_start", n_start, s0 + 1);
    check("bp_job_count", {24'b0, job_count}, 32'd9);

    // Timeout: no done, error result 15 cycles after WAIT entry
    out_ready = 1'b0;
    no_done = 1'b1;
    exp_timeout = 1'b1;
    push_job(16'd1, 16'd2);
    exp_timeout = 1'b0;
    wait_start(10);
    wait_valid(60, n);
    check("to_latency", n, 32'd16);
    check("to_out_err", {31'b0, out_err}, 32'd1);
    check("to_out_data", {16'b0, out_data}, 32'd0);
    out_ready = 1'b1;
    tick();
    no_done = 1'b0;
    push_job(16'd40, 16'd2);
    drain(100);
    check("to_job_count", {24'b0, job_count}, 32'd11);

    // Reset during WAIT with two jobs queued
    push_job(16'd11, 16'd1);
    push_job(16'd12, 16'd1);
    push_job(16'd13, 16'd1);
    tick();
    check("mid_in_wait", {30'b0, dbg_state}, 32'd2);
    rst = 1'b1;
    #1;
    check("mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_acc_start", {31'b0, acc_start}, 32'd0);
    check("mid_acc_a", {16'b0, acc_a}, 32'd0);
    check("mid_acc_b", {16'b0, acc_b}, 32'd0);
    check("mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_out_data", {16'b0, out_data}, 32'd0);
    check("mid_out_err", {31'b0, out_err}, 32'd0);
    check("mid_busy", {31'b0, busy}, 32'd0);
    check("mid_job_count", {24'b0, job_count}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    tick();
    rst = 1'b0;
    repeat (30) tick();
    check("mid_no_output", {31'b0, out_valid}, 32'd0);
    check("mid_idle", {31'b0, busy}, 32'd0);

    // 256 jobs wrap job_count to 0; stray done pulses in IDLE do nothing
    for (int i = 0; i < 256; i++) begin
      push_job(DW'($urandom_range(0, 16'hffff)), DW'($urandom_range(0, 16'hffff)));
    end
    drain(5000);
    check("wrap_job_count", {24'b0, job_count}, 32'd0);
    tb_stray = 1'b1;
    repeat (3) tick();
    tb_stray = 1'b0;
    repeat (3) tick();
    check("stray_no_valid", {31'b0, out_valid}, 32'd0);
    check("stray_job_count", {24'b0, job_count}, 32'd0);
    check("stray_idle", {30'b0, dbg_state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
